// File: rtl/ddr_tx_pkg.sv
// ---------------------------------------------------------------------------
// ddr_tx_pkg
// Shared types and constants for the output DDR transmit path.
//   tx_state_e  : serializer FSM state (ST_IDLE / ST_SHIFT)
//   IDLE_PAIR   : value held in the pair register when nothing is being sent
//   TX_COUNT_W  : width of the issued-word counter
//   pair_cnt_w  : width of the pair counter for a given word width
// ---------------------------------------------------------------------------
package ddr_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

    localparam logic [1:0] IDLE_PAIR  = 2'b00;
    localparam int         TX_COUNT_W = 16;

    // A 2-bit word has a single pair, which $clog2 would size to 0 bits.
    function automatic int pair_cnt_w(input int data_w);
        int w;
        w = $clog2(data_w / 2);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ddr_tx_fifo.sv
// ---------------------------------------------------------------------------
// ddr_tx_fifo
// Small synchronous word FIFO in front of the serializer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, din_i : write din_i (caller guarantees !full_o)
//   pop_i         : advance read pointer (caller guarantees !empty_o)
//   dout_o        : word at the head, valid while !empty_o
//   full_o        : occupancy == FIFO_DEPTH
//   empty_o       : occupancy == 0
//   count_o       : registered occupancy
// ---------------------------------------------------------------------------
module ddr_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [DATA_W-1:0]             din_i,
    output logic [DATA_W-1:0]             dout_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Power-of-2 depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/o_ddr.sv
// ---------------------------------------------------------------------------
// O_DDR
// Behavioural model of the vendor output DDR cell.
//   D[1:0] in  : pair captured on rising C; D[0] drives the high phase,
//                D[1] the low phase of the following cycle
//   E      in  : capture enable
//   R      in  : asynchronous reset, active-high, forces Q to 0
//   C      in  : clock
//   Q      out : pad output
// ---------------------------------------------------------------------------
module O_DDR (
    input  logic [1:0] D,
    input  logic       E,
    input  logic       R,
    input  logic       C,
    output logic       Q
);

    logic [1:0] d_q;

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            d_q <= 2'b00;
        end else if (E) begin
            d_q <= D;
        end
    end

    assign Q = R ? 1'b0 : (C ? d_q[0] : d_q[1]);

endmodule

// File: rtl/output_ddr_tx.sv
// ---------------------------------------------------------------------------
// output_ddr_tx
// Accepts parallel words, buffers them, and sends each word LSB-pair first
// through an O_DDR cell, one bit per clock edge.
//   CLK, RST_N : clock, asynchronous active-low reset
//   DIN        : word to transmit
//   DIN_VALID  : DIN is valid
//   DIN_READY  : FIFO can accept a word
//   Q          : pad output (O_DDR.Q)
//   BUSY       : serializer shifting or FIFO non-empty (registered)
//   TX_COUNT   : words fully issued to O_DDR, wraps at 2^16
//
// Handshake: a word transfers on a rising CLK where DIN_VALID && DIN_READY.
// DIN_READY depends only on registered occupancy, never on a same-cycle pop.
// ---------------------------------------------------------------------------
module output_ddr_tx
    import ddr_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_W-1:0]     DIN,
    input  logic                  DIN_VALID,
    output logic                  DIN_READY,
    output logic                  Q,
    output logic                  BUSY,
    output logic [TX_COUNT_W-1:0] TX_COUNT
);

    localparam int               NPAIRS    = DATA_W / 2;
    localparam int               CNT_W     = pair_cnt_w(DATA_W);
    localparam int               OCC_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NPAIRS - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [DATA_W-1:0]     shifted;
    logic [1:0]            pair_q, pair_d;
    logic                  busy_q, busy_d;
    logic [TX_COUNT_W-1:0] tx_count_q;
    logic                  tx_inc;

    logic                  push, pop;
    logic [DATA_W-1:0]     fifo_dout;
    logic                  fifo_full, fifo_empty;
    logic [OCC_W-1:0]      fifo_count;
    logic [OCC_W-1:0]      occ_next;
    logic                  oddr_rst;

    assign push = DIN_VALID && !fifo_full;

    ddr_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (DIN),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        pair_d  = pair_q;
        pop     = 1'b0;
        tx_inc  = 1'b0;
        shifted = shift_q >> 2;
        case (state_q)
            ST_IDLE: begin
                pair_d = IDLE_PAIR;
                cnt_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    pair_d  = fifo_dout[1:0];
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != LAST_PAIR) begin
                    shift_d = shifted;
                    pair_d  = shifted[1:0];
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    // Leaving the last pair: chain straight into the next
                    // word when one is waiting, so no idle pair appears.
                    tx_inc = 1'b1;
                    cnt_d  = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        pair_d  = fifo_dout[1:0];
                    end else begin
                        pair_d  = IDLE_PAIR;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pair_d  = IDLE_PAIR;
                cnt_d   = '0;
            end
        endcase
    end

    // BUSY is registered from next-cycle state and occupancy.
    assign occ_next = fifo_count + OCC_W'(push) - OCC_W'(pop);
    assign busy_d   = (state_d == ST_SHIFT) || (occ_next != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            pair_q     <= IDLE_PAIR;
            busy_q     <= 1'b0;
            tx_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            pair_q  <= pair_d;
            busy_q  <= busy_d;
            if (tx_inc) begin
                tx_count_q <= tx_count_q + TX_COUNT_W'(1);
            end
        end
    end

    assign oddr_rst = !RST_N;

    O_DDR u_oddr (
        .D (pair_q),
        .E (1'b1),
        .R (oddr_rst),
        .C (CLK),
        .Q (Q)
    );

    assign DIN_READY = !fifo_full;
    assign BUSY      = busy_q;
    assign TX_COUNT  = tx_count_q;

endmodule

// File: tb/tb_output_ddr_tx.sv
// ---------------------------------------------------------------------------
// tb_output_ddr_tx
// Reference model: every accepted word gets a start cycle S (edge at which
// O_DDR captures its pair 0): S = max(accept_edge + 2, previous_S + DATA_W/2).
// From that the bench derives the pad bit in each half-cycle, the FIFO
// occupancy (word held until edge S-1), BUSY (until edge S+P-2) and
// TX_COUNT (word counted from edge S+P-1).
// ---------------------------------------------------------------------------
module tb_output_ddr_tx;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int NP         = DATA_W / 2;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [DATA_W-1:0] DIN = '0;
  logic              DIN_VALID = 1'b0;
  logic              DIN_READY;
  logic              Q;
  logic              BUSY;
  logic [15:0]       TX_COUNT;

  output_ddr_tx #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .Q         (Q),
    .BUSY      (BUSY),
    .TX_COUNT  (TX_COUNT)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int edge_n = 0;
  always @(posedge CLK) edge_n <= edge_n + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  int                st_q[$];
  int                last_st = -100;
  logic [15:0]       done_cnt = '0;
  int                n_cmp = 0;
  int                n_fail = 0;
  bit                saw_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model update on an accepted word (called #1 after the accepting edge).
  task automatic record_push(input logic [DATA_W-1:0] w);
    int s;
    s = edge_n + 2;
    if (last_st + NP > s) s = last_st + NP;
    last_st = s;
    exp_q.push_back(w);
    st_q.push_back(s);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [DATA_W-1:0] w);
    int  tries;
    bit  done;
    tries = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge CLK);
      DIN_VALID = 1'b1;
      DIN       = w;
      if (DIN_READY) begin
        @(posedge CLK);
        #1;
        record_push(w);
        done = 1'b1;
      end else begin
        tries++;
        if (tries > 200) begin
          n_cmp++;
          n_fail++;
          $display("FAIL send_timeout: got ready=0 for 200 cycles expected ready=1");
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      DIN_VALID = 1'b0;
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge CLK);
    RST_N     = 1'b0;
    DIN_VALID = 1'b0;
    exp_q.delete();
    st_q.delete();
    done_cnt  = '0;
    last_st   = -100;
    repeat (cycles) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() > 0 && b < 500) begin
      @(posedge CLK);
      b++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
    end
    repeat (3) @(posedge CLK);
  endtask

  // ---------------- monitor ----------------
  task automatic check_phase(input bit high);
    int                c;
    int                k;
    int                occ;
    logic              eq;
    logic              eb;
    logic [15:0]       etx;
    logic [DATA_W-1:0] hw;
    c = edge_n;
    if (!RST_N) begin
      chk("q_in_reset", {31'd0, Q}, 32'd0);
      if (high) begin
        chk("ready_in_reset", {31'd0, DIN_READY}, 32'd1);
        chk("busy_in_reset", {31'd0, BUSY}, 32'd0);
        chk("txcount_in_reset", {16'd0, TX_COUNT}, 32'd0);
      end
      return;
    end
    eq = 1'b0;
    if (exp_q.size() > 0) begin
      if (c >= st_q[0] && c <= st_q[0] + NP - 1) begin
        hw = exp_q[0];
        k  = c - st_q[0];
        eq = high ? hw[2*k] : hw[2*k+1];
      end
    end
    chk(high ? "q_high" : "q_low", {31'd0, Q}, {31'd0, eq});
    if (high) begin
      occ = 0;
      eb  = 1'b0;
      etx = done_cnt;
      foreach (st_q[i]) begin
        if (st_q[i] - 1 > c) occ++;
        if (c <= st_q[i] + NP - 2) eb = 1'b1;
        if (st_q[i] + NP - 1 <= c) etx = etx + 16'd1;
      end
      chk("din_ready", {31'd0, DIN_READY}, {31'd0, (occ < FIFO_DEPTH)});
      chk("busy", {31'd0, BUSY}, {31'd0, eb});
      chk("tx_count", {16'd0, TX_COUNT}, {16'd0, etx});
      if (!DIN_READY) saw_full = 1'b1;
    end else if (exp_q.size() > 0) begin
      if (c == st_q[0] + NP - 1) begin
        void'(exp_q.pop_front());
        void'(st_q.pop_front());
        done_cnt = done_cnt + 16'd1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #2;
      check_phase(1'b1);
      @(negedge CLK);
      #2;
      check_phase(1'b0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int s_c3;
    logic [DATA_W-1:0] w;

    // Reset values, then a quiet line after release.
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    idle(20);

    // Single word 0xB4.
    send_word(8'hB4);
    idle(1);
    drain();
    chk("tx_single", {16'd0, TX_COUNT}, 32'd1);

    // Back-to-back 0xFF, 0x00, 0xA5.
    send_word(8'hFF);
    send_word(8'h00);
    send_word(8'hA5);
    idle(1);
    drain();
    chk("tx_back_to_back", {16'd0, TX_COUNT}, 32'd4);

    // Six words back-to-back overrun the 4-deep FIFO.
    saw_full = 1'b0;
    repeat (6) begin
      w = DATA_W'($urandom);
      send_word(w);
    end
    idle(1);
    drain();
    chk("ready_dropped", {31'd0, saw_full}, 32'd1);

    // Reset during pair 2 of 0xC3 with two words queued behind it.
    send_word(8'hC3);
    s_c3 = last_st;
    send_word(DATA_W'($urandom));
    send_word(DATA_W'($urandom));
    idle(1);
    while (edge_n < s_c3 + 2) begin
      @(posedge CLK);
      #1;
    end
    apply_reset(2);
    idle(10);
    send_word(8'h5A);
    send_word(8'h3C);
    idle(1);
    drain();
    chk("tx_after_reset", {16'd0, TX_COUNT}, 32'd2);

    // Randomized words with random gaps.
    for (int i = 0; i < 40; i++) begin
      w = DATA_W'($urandom);
      send_word(w);
      idle($urandom_range(0, 3));
    end
    idle(1);
    drain();

    // Counter wrap: preload near the top, then stream three words.
    @(negedge CLK);
    #3;
    force dut.tx_count_q = 16'hFFFE;
    done_cnt = 16'hFFFE;
    #1;
    release dut.tx_count_q;
    send_word(DATA_W'($urandom));
    send_word(DATA_W'($urandom));
    send_word(DATA_W'($urandom));
    idle(1);
    drain();
    chk("tx_wrap", {16'd0, TX_COUNT}, 32'd1);

    repeat (5) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
